// File: rtl/crop_axis_pkg.sv
// -----------------------------------------------------------------------------
// crop_axis_pkg
// Shared definitions for the crop video pipeline AXI4-Stream blocks:
//   - default TDATA width, FIFO depth and line width
//   - helper functions that size the FIFO pointers, the occupancy counter and
//     the per-line beat counter
// -----------------------------------------------------------------------------
package crop_axis_pkg;

  localparam int unsigned DEF_TDATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_LINE_WIDTH  = 640;

  // Read/write pointer width for a power-of-2 depth.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must hold the value 'depth' itself (full).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Beat-in-line counter width: must hold the value 'line_width' itself.
  function automatic int unsigned pix_width(input int unsigned line_width);
    return $clog2(line_width) + 1;
  endfunction

endpackage

// File: rtl/axis_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// axis_rx_fifo_mem
// Register-array storage for the S00 receive FIFO: one synchronous write port
// and one asynchronous read port, so the FIFO head is visible combinationally
// (first-word-fall-through).
// Ports:
//   clk      in   write clock (rising edge)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data ({tdata, tlast, tuser})
//   rd_addr  in   read address
//   rd_data  out  contents of rd_addr, no clock latency
// -----------------------------------------------------------------------------
module axis_rx_fifo_mem #(
  parameter int unsigned DW    = 34,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // Payload storage only; validity is tracked by the pointers in the parent,
  // so the array itself needs no reset.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/s00_axis_rx_fifo.sv
// -----------------------------------------------------------------------------
// s00_axis_rx_fifo
// AXI4-Stream slave for the crop pipeline. Accepted pixel beats are buffered in
// a first-word-fall-through FIFO that the crop core drains with rd_en/empty.
// Line framing is checked on every accepted beat: TUSER marks beat 1 of a
// frame/line, TLAST must land exactly on beat C_LINE_WIDTH.
//
// Handshake: a beat transfers on a rising edge where S_AXIS_TVALID and
// S_AXIS_TREADY are both high. TREADY depends only on the registered FIFO
// count (never on TVALID); TDATA/TLAST/TUSER are not sampled otherwise. On the
// read side, a pop happens on a rising edge where rd_en is high and empty is
// low; rd_en while empty is ignored.
//
// Ports:
//   S_AXIS_ACLK    in   sole clock, rising edge
//   S_AXIS_ARESET  in   asynchronous active-high reset
//   S_AXIS_TDATA   in   beat data
//   S_AXIS_TSTRB   in   byte qualifiers (ignored, all bytes valid)
//   S_AXIS_TVALID  in   upstream beat valid
//   S_AXIS_TREADY  out  FIFO has space
//   S_AXIS_TLAST   in   end of line
//   S_AXIS_TUSER   in   start of frame
//   rd_en          in   pop request
//   empty          out  FIFO holds no beat
//   data_out       out  head beat data (valid when !empty)
//   last_out       out  head beat TLAST
//   user_out       out  head beat TUSER
//   fifo_cnt       out  occupancy 0..C_S_AXIS_FIFO_DEPTH
//   eol_err        out  one-cycle pulse after a mis-framed beat is accepted
// -----------------------------------------------------------------------------
module s00_axis_rx_fifo
  import crop_axis_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int unsigned C_S_AXIS_FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned C_LINE_WIDTH         = DEF_LINE_WIDTH
) (
  input  logic                                     S_AXIS_ACLK,
  input  logic                                     S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]          S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]        S_AXIS_TSTRB,
  input  logic                                     S_AXIS_TVALID,
  output logic                                     S_AXIS_TREADY,
  input  logic                                     S_AXIS_TLAST,
  input  logic                                     S_AXIS_TUSER,
  input  logic                                     rd_en,
  output logic                                     empty,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]          data_out,
  output logic                                     last_out,
  output logic                                     user_out,
  output logic [cnt_width(C_S_AXIS_FIFO_DEPTH)-1:0] fifo_cnt,
  output logic                                     eol_err
);

  localparam int unsigned W   = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned D   = C_S_AXIS_FIFO_DEPTH;
  localparam int unsigned PW  = ptr_width(D);
  localparam int unsigned CW  = cnt_width(D);
  localparam int unsigned PXW = pix_width(C_LINE_WIDTH);

  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt_q;
  logic [PXW-1:0] pix_cnt, beat_num, pix_next;
  logic           push, pop, frame_err;
  logic [W+1:0]   head;

  // TSTRB carries no information for this pipeline.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  // ---------------------------------------------------------------------------
  // Handshake and flags (all from registered count: no flag lag, no bypass)
  // ---------------------------------------------------------------------------
  assign S_AXIS_TREADY = (cnt_q != CW'(D));
  assign empty         = (cnt_q == '0);
  assign fifo_cnt      = cnt_q;
  assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop           = rd_en & ~empty;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  axis_rx_fifo_mem #(
    .DW    (W + 2),
    .DEPTH (D),
    .AW    (PW)
  ) u_mem (
    .clk     (S_AXIS_ACLK),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data ({S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TUSER}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  assign {data_out, last_out, user_out} = head;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(D - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(D - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Framing checker
  // pix_cnt holds the number of beats already accepted in the current line.
  // A TUSER beat starts a new line as beat 1 regardless of history. Both an
  // EOL on the wrong beat and a missing EOL at beat C_LINE_WIDTH return the
  // counter to 0 so the next beat starts a fresh line.
  // ---------------------------------------------------------------------------
  always_comb begin
    beat_num  = S_AXIS_TUSER ? PXW'(1) : pix_cnt + PXW'(1);
    pix_next  = beat_num;
    frame_err = 1'b0;
    if (S_AXIS_TLAST) begin
      frame_err = (beat_num != PXW'(C_LINE_WIDTH));
      pix_next  = '0;
    end else if (beat_num == PXW'(C_LINE_WIDTH)) begin
      frame_err = 1'b1;
      pix_next  = '0;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      pix_cnt <= '0;
      eol_err <= 1'b0;
    end else begin
      if (push) pix_cnt <= pix_next;
      eol_err <= push & frame_err;
    end
  end

endmodule

// File: tb/tb_s00_axis_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_s00_axis_rx_fifo
// Directed bench for s00_axis_rx_fifo (W=32, D=16, line width 640).
// A reference occupancy count and an expected-beat queue are kept alongside
// the stimulus; every cycle the flags are compared against the reference and
// every pop compares the FIFO head against the oldest queued beat. Framing
// errors are expected only on beats the stimulus deliberately mis-frames.
// -----------------------------------------------------------------------------
module tb_s00_axis_rx_fifo;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LW = 640;
  localparam int CW = $clog2(D) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tvalid, tready, tlast, tuser;
  logic           rd_en, empty, last_out, user_out, eol_err;
  logic [W-1:0]   data_out;
  logic [CW-1:0]  fifo_cnt;

  s00_axis_rx_fifo #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .C_S_AXIS_FIFO_DEPTH  (D),
    .C_LINE_WIDTH         (LW)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TUSER  (tuser),
    .rd_en         (rd_en),
    .empty         (empty),
    .data_out      (data_out),
    .last_out      (last_out),
    .user_out      (user_out),
    .fifo_cnt      (fifo_cnt),
    .eol_err       (eol_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W+1:0] exp_q[$];
  int           exp_cnt  = 0;
  logic         exp_eol  = 1'b0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Outputs are compared at the falling edge (they
  // reflect the previous rising edge), then the new inputs are applied for the
  // next rising edge and the reference model is advanced.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                       input logic u, input logic rd, input logic err_on_push);
    logic         do_push, do_pop;
    logic [W+1:0] head;
    @(negedge clk);
    check("eol_err",  64'(eol_err),  64'(exp_eol));
    check("fifo_cnt", 64'(fifo_cnt), 64'(exp_cnt));
    check("tready",   64'(tready),   64'(exp_cnt != D));
    check("empty",    64'(empty),    64'(exp_cnt == 0));
    do_push = v && (exp_cnt != D);
    do_pop  = rd && (exp_cnt != 0);
    if (do_pop) begin
      head = exp_q.pop_front();
      check("head", 64'({data_out, last_out, user_out}), 64'(head));
    end
    if (do_push) exp_q.push_back({d, l, u});
    exp_cnt = exp_cnt + int'(do_push) - int'(do_pop);
    exp_eol = do_push && err_on_push;
    tvalid = v;
    tdata  = d;
    tlast  = l;
    tuser  = u;
    tstrb  = 4'($urandom_range(0, 15));
    rd_en  = rd;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, rd, 1'b0);
  endtask

  // One line of random pixels with rd_en held high so the FIFO never fills.
  // last_at/err_at of 0 mean "no TLAST"/"no framing error expected".
  task automatic send_line(input int n, input bit first_user, input int last_at, input int err_at);
    for (int i = 1; i <= n; i++)
      cycle(1'b1, W'($urandom_range(0, 32'hFFFF_FFFF)), (i == last_at),
            (first_user && i == 1), 1'b1, (i == err_at));
    idle(3, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst    = 1'b1;
    tvalid = 1'b0;
    rd_en  = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    #1;
    check("rst_empty",    64'(empty),    64'd1);
    check("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("rst_tready",   64'(tready),   64'd1);
    check("rst_eol_err",  64'(eol_err),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    exp_eol = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    tvalid = 1'b0;
    tdata  = '0;
    tstrb  = '0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    rd_en  = 1'b0;
    repeat (2) @(negedge clk);
    check("init_empty",    64'(empty),    64'd1);
    check("init_fifo_cnt", 64'(fifo_cnt), 64'd0);
    check("init_tready",   64'(tready),   64'd1);
    check("init_eol_err",  64'(eol_err),  64'd0);
    rst = 1'b0;

    // 1: fill with 0x1..0x10, then a 17th offer sees TREADY low, count 16.
    for (int i = 1; i <= D; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, W'(32'h11), 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_head", 64'(data_out), 64'h1);

    // 2: full with push and pop together: only the pop happens.
    cycle(1'b1, W'(32'h12), 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: drain to 5, then 40 cycles of simultaneous push/pop across the wrap.
    idle(10, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);
    // rd_en while empty must leave the FIFO untouched.
    idle(2, 1'b1);

    // 4: correct line, then TLAST one beat early.
    send_line(LW, 1'b1, LW, 0);
    send_line(LW - 1, 1'b1, LW - 1, LW - 1);

    // 5: missing TLAST, then a clean line that relies on the resync.
    send_line(LW, 1'b1, 0, LW);
    send_line(LW, 1'b0, LW, 0);

    // 6: reset with 9 beats buffered mid-line.
    for (int i = 1; i <= 9; i++)
      cycle(1'b1, W'(32'h200 + i), 1'b0, (i == 1), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset();
    send_line(LW, 1'b0, LW, 0);
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
